// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
//   Eight-byte transmit queue sitting in front of a UART transmitter. Bytes
//   are written one per cycle, and the queue offers them one at a time to
//   the transmitter using a single-cycle offer strobe. Each offer is retired
//   (popped) on the cycle the transmitter takes it. The queue then waits for
//   the transmitter's busy period to start and to end before it offers the
//   next byte.
//
// Ports
//   clk           in   rising-edge clock for all state
//   rst_n         in   synchronous active-low reset
//   wr_data[7:0]  in   byte to enqueue
//   wr_en         in   enqueue strobe, one byte per cycle
//   flush         in   discard every queued byte, clear overflow
//   ovf_clr       in   clear the sticky overflow flag
//   full          out  count == 8
//   empty         out  count == 0
//   count[3:0]    out  number of queued bytes, 0..8
//   overflow      out  sticky: a write arrived while full and was dropped
//   data_tx[7:0]  out  byte currently offered to the transmitter
//   have_data_tx  out  offer strobe to the transmitter
//   transmitting  in   transmitter busy; rises the cycle after it takes an offer

module uart_tx_fifo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] wr_data,
  input  logic       wr_en,
  input  logic       flush,
  input  logic       ovf_clr,
  output logic       full,
  output logic       empty,
  output logic [3:0] count,
  output logic       overflow,
  output logic [7:0] data_tx,
  output logic       have_data_tx,
  input  logic       transmitting
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_END
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] mem_q [8];
  logic [7:0] mem_d [8];
  logic [2:0] wr_ptr_q, wr_ptr_d;
  logic [2:0] rd_ptr_q, rd_ptr_d;
  logic [3:0] count_q, count_d;
  logic       ovf_q, ovf_d;
  logic [7:0] data_q, data_d;
  logic       have_q, have_d;
  logic       flushed_q, flushed_d;
  logic       push, drop, pop;

  assign full         = (count_q == 4'd8);
  assign empty        = (count_q == 4'd0);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign data_tx      = data_q;
  assign have_data_tx = have_q;

  // A write that meets a full queue is dropped even if a pop happens in the
  // same cycle. A flush overrides every write.
  assign push = wr_en && !full && !flush;
  assign drop = wr_en &&  full && !flush;

  // Offer sequencing. An offer that a flush has hit must still complete its
  // handshake with the transmitter, because the transmitter may already be
  // committed to it. flushed_q remembers that such an offer must not pop.
  // Without it, the pop could remove a byte written after the flush, and
  // that byte would never be sent.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    have_d  = have_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (count_q != 4'd0 && !transmitting) begin
          data_d  = mem_q[rd_ptr_q];
          have_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (!transmitting) begin
          pop     = !flush && !flushed_q;
          have_d  = 1'b0;
          state_d = WAIT_START;
        end
      end
      WAIT_START: begin
        if (transmitting) begin
          state_d = WAIT_END;
        end
      end
      WAIT_END: begin
        if (!transmitting) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    flushed_d = (state_d == ISSUE) && (flush || flushed_q);
  end

  // Circular buffer bookkeeping. A push and a pop in the same cycle advance
  // both pointers and leave the count unchanged. In the overflow flag, a
  // dropped write takes priority over ovf_clr.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = 3'd0;
      rd_ptr_d = 3'd0;
      count_d  = 4'd0;
      ovf_d    = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + 3'd1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 3'd1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
      if (drop) begin
        ovf_d = 1'b1;
      end else if (ovf_clr) begin
        ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= 3'd0;
      rd_ptr_q  <= 3'd0;
      count_q   <= 4'd0;
      ovf_q     <= 1'b0;
      data_q    <= 8'h00;
      have_q    <= 1'b0;
      flushed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      data_q    <= data_d;
      have_q    <= have_d;
      flushed_q <= flushed_d;
    end
  end

  // Storage has no reset. Stale entries are never offered, because the
  // count governs what is readable.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
